mdl_timer25k_seq: RTL and testbench

// Timing/control stage directly upstream of the 2556-count cycle timer.
// - Generates the 20-phase active-low one-hot rotator ROT20_n that frames every serial timer operation.
// - Sequences the timer's count enable (TIMER25K_CNT) and output-latch load (TIMER25K_OUTLATCH_LD_n).
// - Watches TIMEOVER_n and reports done/abort to the controller core.

---
 rtl/mdl_timer25k_seq.sv | 160 ++++++++++++++++
 tb/tb_mdl_timer25k_seq.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdl_timer25k_seq.sv
// Phase rotator and IDLE/ARM/RUN/SNAP/CLEAR sequencer that drives the 2556-count cycle timer.
// Every output is a register, and state changes only on cycles where i_CLK2M_PCEN_n is low.
module mdl_timer25k_seq #(
  parameter int TIMEOVER_PHASE = 13,
  parameter int LATCH_PHASE    = 0,
  parameter int CLEAR_FRAMES   = 1,
  parameter int EXP_CNT_W      = 8
) (
  input  logic                 i_MCLK,
  input  logic                 i_RST,
  input  logic                 i_CLK2M_PCEN_n,
  input  logic                 i_TIMER_START,
  input  logic                 i_TIMER_ABORT,
  input  logic                 i_TIMER25K_TIMEOVER_n,
  output logic [19:0]          o_ROT20_n,
  output logic                 o_TIMER25K_CNT,
  output logic                 o_TIMER25K_OUTLATCH_LD_n,
  output logic                 o_BUSY,
  output logic                 o_DONE,
  output logic                 o_ABORTED,
  output logic [EXP_CNT_W-1:0] o_EXPIRE_CNT
);

  typedef enum logic [2:0] {IDLE, ARM, RUN, SNAP, CLEAR} state_t;

  localparam int PRE_LATCH = (LATCH_PHASE + 19) % 20;

  state_t               state_q, state_d;
  logic [19:0]          rot_q, rot_d;
  logic                 cnt_q, cnt_d;
  logic                 ldN_q, ldN_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 aborted_q, aborted_d;
  logic                 reasonAbort_q, reasonAbort_d;
  logic                 crossed_q, crossed_d;
  logic [1:0]           frameCnt_q, frameCnt_d;
  logic [EXP_CNT_W-1:0] expireCnt_q, expireCnt_d;

  logic tickEn, atBoundary, timeoverHit, nextIsLatch, lastClear, finishOp;

  assign tickEn      = ~i_CLK2M_PCEN_n;
  assign atBoundary  = ~rot_q[19];
  assign timeoverHit = ~rot_q[TIMEOVER_PHASE] & ~i_TIMER25K_TIMEOVER_n;
  assign nextIsLatch = ~rot_q[PRE_LATCH];
  assign lastClear   = (frameCnt_q == 2'(CLEAR_FRAMES - 1));

  // Next-state logic. The pulses and the LD strobe default to inactive on every enabled tick.
  // crossed_q marks that SNAP has passed its first frame boundary, where CNT drops to 0.
  always_comb begin
    state_d       = state_q;
    rot_d         = rot_q;
    cnt_d         = cnt_q;
    ldN_d         = ldN_q;
    done_d        = done_q;
    aborted_d     = aborted_q;
    reasonAbort_d = reasonAbort_q;
    crossed_d     = crossed_q;
    frameCnt_d    = frameCnt_q;
    expireCnt_d   = expireCnt_q;
    finishOp      = 1'b0;
    if (tickEn) begin
      rot_d     = {rot_q[18:0], rot_q[19]};
      done_d    = 1'b0;
      aborted_d = 1'b0;
      ldN_d     = 1'b1;
      case (state_q)
        IDLE: begin
          if (i_TIMER_START && !i_TIMER_ABORT) state_d = ARM;
        end
        ARM: begin
          if (i_TIMER_ABORT) begin
            state_d   = IDLE;
            aborted_d = 1'b1;
          end else if (atBoundary) begin
            state_d = RUN;
            cnt_d   = 1'b1;
          end
        end
        RUN: begin
          if (timeoverHit || i_TIMER_ABORT) begin
            state_d       = SNAP;
            reasonAbort_d = ~timeoverHit;
            crossed_d     = 1'b0;
          end
        end
        SNAP: begin
          if (atBoundary && !crossed_q) begin
            crossed_d  = 1'b1;
            cnt_d      = 1'b0;
            frameCnt_d = '0;
          end else if (atBoundary) begin
            frameCnt_d = frameCnt_q + 2'd1;
          end
          if (!ldN_q) begin
            if (atBoundary && crossed_q && lastClear) finishOp = 1'b1;
            else state_d = CLEAR;
          end else if ((crossed_q || atBoundary) && nextIsLatch) begin
            ldN_d = 1'b0;
          end
        end
        CLEAR: begin
          if (atBoundary) begin
            if (lastClear) finishOp = 1'b1;
            else frameCnt_d = frameCnt_q + 2'd1;
          end
        end
        default: state_d = IDLE;
      endcase
      if (finishOp) begin
        state_d = IDLE;
        if (reasonAbort_q) begin
          aborted_d = 1'b1;
        end else begin
          done_d = 1'b1;
          if (expireCnt_q != '1) expireCnt_d = expireCnt_q + 1'b1;
        end
      end
    end
    busy_d = (state_d != IDLE);
  end

  // State register. Reset parks the rotator at phase 0.
  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state_q       <= IDLE;
      rot_q         <= 20'hFFFFE;
      cnt_q         <= 1'b0;
      ldN_q         <= 1'b1;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      aborted_q     <= 1'b0;
      reasonAbort_q <= 1'b0;
      crossed_q     <= 1'b0;
      frameCnt_q    <= '0;
      expireCnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      rot_q         <= rot_d;
      cnt_q         <= cnt_d;
      ldN_q         <= ldN_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      aborted_q     <= aborted_d;
      reasonAbort_q <= reasonAbort_d;
      crossed_q     <= crossed_d;
      frameCnt_q    <= frameCnt_d;
      expireCnt_q   <= expireCnt_d;
    end
  end

  assign o_ROT20_n                = rot_q;
  assign o_TIMER25K_CNT           = cnt_q;
  assign o_TIMER25K_OUTLATCH_LD_n = ldN_q;
  assign o_BUSY                   = busy_q;
  assign o_DONE                   = done_q;
  assign o_ABORTED                = aborted_q;
  assign o_EXPIRE_CNT             = expireCnt_q;

endmodule

// File: tb/tb_mdl_timer25k_seq.sv
// Directed bench for mdl_timer25k_seq. It covers the rotator, timeover and abort sequencing,
// enable gaps, reset during an operation, and saturation of the expiry counter.
`timescale 1ns/1ps
module tb_mdl_timer25k_seq;

  logic        clock = 1'b0;
  logic        reset;
  logic        pcenN;
  logic        timerStart;
  logic        timerAbort;
  logic        timeoverN;
  logic [19:0] rotN;
  logic        cntOut;
  logic        ldN;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [7:0]  expireCnt;

  int compareCount = 0;
  int failCount    = 0;
  int tbPhase      = 0;
  int gapCycles    = 0;
  int frame        = 0;

  mdl_timer25k_seq dut (
    .i_MCLK                   (clock),
    .i_RST                    (reset),
    .i_CLK2M_PCEN_n           (pcenN),
    .i_TIMER_START            (timerStart),
    .i_TIMER_ABORT            (timerAbort),
    .i_TIMER25K_TIMEOVER_n    (timeoverN),
    .o_ROT20_n                (rotN),
    .o_TIMER25K_CNT           (cntOut),
    .o_TIMER25K_OUTLATCH_LD_n (ldN),
    .o_BUSY                   (busy),
    .o_DONE                   (done),
    .o_ABORTED                (aborted),
    .o_EXPIRE_CNT             (expireCnt)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rotExp(input int p);
    logic [19:0] v;
    v    = 20'hFFFFF;
    v[p] = 1'b0;
    return {12'h000, v};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One enabled tick, optionally preceded by disabled cycles during which the outputs must hold.
  task automatic applyStimulus(input logic start, input logic abort, input logic toN);
    timerStart = start;
    timerAbort = abort;
    timeoverN  = toN;
    for (int g = 0; g < gapCycles; g++) begin
      pcenN = 1'b1;
      @(posedge clock);
      #1;
      checkOutput("gapHold", {12'h000, rotN}, rotExp(tbPhase));
    end
    pcenN = 1'b0;
    @(posedge clock);
    #1;
    pcenN   = 1'b1;
    tbPhase = (tbPhase + 1) % 20;
  endtask

  // Expects IDLE at phase 7. START is issued here, timeover occurs in phase 13 of frame toFrame,
  // and the task returns at phase 1 after the DONE pulse.
  task automatic runTimeover(input int toFrame, input logic [7:0] expAfter);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("armBusy", 32'(busy), 32'd1);
    checkOutput("armCnt", 32'(cntOut), 32'd0);
    repeat (11) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("armPh19Rot", {12'h000, rotN}, rotExp(19));
    checkOutput("armPh19Cnt", 32'(cntOut), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("runStartRot", {12'h000, rotN}, rotExp(0));
    checkOutput("runStartCnt", 32'(cntOut), 32'd1);
    frame = 1;
    while (!(frame == toFrame && tbPhase == 13)) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (tbPhase == 0) begin
        frame++;
        checkOutput("runFrameCnt", 32'(cntOut), 32'd1);
        checkOutput("runFrameLd", 32'(ldN), 32'd1);
      end
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("snapCnt", 32'(cntOut), 32'd1);
    checkOutput("snapLd", 32'(ldN), 32'd1);
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("snapPh19Cnt", 32'(cntOut), 32'd1);
    checkOutput("snapPh19Ld", 32'(ldN), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("latchRot", {12'h000, rotN}, rotExp(0));
    checkOutput("latchLd", 32'(ldN), 32'd0);
    checkOutput("latchCnt", 32'(cntOut), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clearLd", 32'(ldN), 32'd1);
    checkOutput("clearCnt", 32'(cntOut), 32'd0);
    checkOutput("clearBusy", 32'(busy), 32'd1);
    repeat (18) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("clearEndDone", 32'(done), 32'd0);
    checkOutput("clearEndCnt", 32'(cntOut), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("donePulse", 32'(done), 32'd1);
    checkOutput("doneBusy", 32'(busy), 32'd0);
    checkOutput("doneAborted", 32'(aborted), 32'd0);
    checkOutput("doneExpire", 32'(expireCnt), 32'(expAfter));
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("doneEnd", 32'(done), 32'd0);
  endtask

  initial begin
    logic seen;
    reset      = 1'b1;
    pcenN      = 1'b1;
    timerStart = 1'b0;
    timerAbort = 1'b0;
    timeoverN  = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rstRot", {12'h000, rotN}, 32'h000FFFFE);
    checkOutput("rstCnt", 32'(cntOut), 32'd0);
    checkOutput("rstLd", 32'(ldN), 32'd1);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstAborted", 32'(aborted), 32'd0);
    checkOutput("rstExpire", 32'(expireCnt), 32'd0);
    reset   = 1'b0;
    tbPhase = 0;

    $display("[TB] scenario 1: free-running rotator");
    for (int i = 0; i < 45; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("idleBusy", 32'(busy), 32'd0);
      checkOutput("idleDone", 32'(done), 32'd0);
    end
    checkOutput("rot45", {12'h000, rotN}, 32'h000FFFDF);

    $display("[TB] scenario 2: full timeover at frame 2556");
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
    runTimeover(2556, 8'd1);

    $display("[TB] scenario 3: abort in RUN frame 10");
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (17) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abRunCnt", 32'(cntOut), 32'd1);
    frame = 1;
    while (!(frame == 10 && tbPhase == 5)) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (tbPhase == 0) frame++;
    end
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("abSnapBusy", 32'(busy), 32'd1);
    checkOutput("abSnapCnt", 32'(cntOut), 32'd1);
    repeat (13) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("abSnapPh19Ld", 32'(ldN), 32'd1);
    checkOutput("abSnapPh19Cnt", 32'(cntOut), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abLatchLd", 32'(ldN), 32'd0);
    checkOutput("abLatchCnt", 32'(cntOut), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("abClearLd", 32'(ldN), 32'd1);
    checkOutput("abClearBusy", 32'(busy), 32'd1);
    checkOutput("abClearAborted", 32'(aborted), 32'd0);
    repeat (18) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abPulse", 32'(aborted), 32'd1);
    checkOutput("abDone", 32'(done), 32'd0);
    checkOutput("abBusy", 32'(busy), 32'd0);
    checkOutput("abExpire", 32'(expireCnt), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abPulseEnd", 32'(aborted), 32'd0);

    $display("[TB] scenario 4: corner cases");
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("startAbortIdleBusy", 32'(busy), 32'd0);
    checkOutput("startAbortIdleAb", 32'(aborted), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("startAbortIdleAb2", 32'(aborted), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("armAbBusy1", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("armAbBusy0", 32'(busy), 32'd0);
    checkOutput("armAbPulse", 32'(aborted), 32'd1);
    checkOutput("armAbLd", 32'(ldN), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("armAbPulseEnd", 32'(aborted), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (12) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("s4RunRot", {12'h000, rotN}, rotExp(0));
    checkOutput("s4RunCnt", 32'(cntOut), 32'd1);
    frame = 1;
    for (int t = 0; t < 60; t++) begin
      applyStimulus((frame == 2 && tbPhase == 3) ? 1'b1 : 1'b0, 1'b0,
                    (tbPhase == 12 || tbPhase == 14) ? 1'b0 : 1'b1);
      if (tbPhase == 0) frame++;
      checkOutput("offPhaseCnt", 32'(cntOut), 32'd1);
      checkOutput("offPhaseLd", 32'(ldN), 32'd1);
    end
    checkOutput("offPhaseBusy", 32'(busy), 32'd1);
    repeat (13) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("bothLd", 32'(ldN), 32'd0);
    repeat (20) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("bothDone", 32'(done), 32'd1);
    checkOutput("bothAborted", 32'(aborted), 32'd0);
    checkOutput("bothExpire", 32'(expireCnt), 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1);

    $display("[TB] scenario 5: enable gaps");
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b1);
    gapCycles = 3;
    runTimeover(3, 8'd3);
    gapCycles = 0;

    $display("[TB] scenario 6: reset in SNAP, then saturation");
    applyStimulus(1'b1, 1'b0, 1'b1);
    repeat (18) applyStimulus(1'b0, 1'b0, 1'b1);
    repeat (13) applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("preRstBusy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midRstRot", {12'h000, rotN}, 32'h000FFFFE);
    checkOutput("midRstCnt", 32'(cntOut), 32'd0);
    checkOutput("midRstLd", 32'(ldN), 32'd1);
    checkOutput("midRstBusy", 32'(busy), 32'd0);
    checkOutput("midRstDone", 32'(done), 32'd0);
    checkOutput("midRstExpire", 32'(expireCnt), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    tbPhase = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("postRstDone", 32'(done), 32'd0);
    end
    checkOutput("postRstRot", {12'h000, rotN}, rotExp(5));
    repeat (15) applyStimulus(1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 256; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (18) applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b1);
      repeat (13) applyStimulus(1'b0, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b0, 1'b0);
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
        applyStimulus(1'b0, 1'b0, 1'b1);
        if (done) seen = 1'b1;
      end
      checkOutput("satDoneSeen", 32'(seen), 32'd1);
      checkOutput("satExpire", 32'(expireCnt), (i < 255) ? 32'(i) : 32'd255);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
